// File: rtl/multicycle_control_unit.sv
// Control FSM for the multi-cycle RISC-V datapath: sequences each instruction,
// handshakes with variable-latency memory, aborts on timeout/illegal opcode and counts retirements.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_2_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             error,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  // A zero timeout disables the counter, but it still needs at least one bit to exist.
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ALU_WB   = 4'd10,
    HALT     = 4'd11
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic               waiting;
  logic               goto_halt;
  logic               timeout_hit;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      error_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      error_q   <= error_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_2_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    pc_source = 2'b00;
    retire    = 1'b0;
    waiting   = 1'b0;
    goto_halt = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
        else           waiting = 1'b1;
      end
      DECODE: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_R:               state_d = EXEC_R;
          OP_I:               state_d = EXEC_I;
          OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
          OP_BRANCH:          state_d = BRANCH;
          OP_JAL:             state_d = JUMP;
          default: begin
            state_d   = HALT;
            goto_halt = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = MEM_WB;
        else           waiting = 1'b1;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem_2_reg = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = state_q;
    endcase

    // A ready in the final allowed wait cycle still completes the handshake.
    timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT));
    if (waiting && timeout_hit) begin
      state_d   = HALT;
      goto_halt = 1'b1;
    end

    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_q + WAIT_W'(1);
    else                    wait_d = wait_q;

    error_d   = error_q | goto_halt;
    retired_d = retired_q + CNT_W'(retire);
  end

  assign error   = error_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus a randomized
// instruction stream checked against an instruction-level trace model.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b0000000;

  logic        clk = 1'b0;
  logic        arst;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        zero;

  logic        pc_write, ir_write, i_or_d, mem_read, mem_write, mem_2_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        error;
  logic [31:0] retired;
  logic [3:0]  state;

  logic        pc_write_w, ir_write_w, i_or_d_w, mem_read_w, mem_write_w, mem_2_reg_w, reg_write_w;
  logic        alu_src_a_w, error_w;
  logic [1:0]  alu_src_b_w, alu_op_w, pc_source_w;
  logic [3:0]  retired_w;
  logic [3:0]  state_w;

  multicycle_control_unit #(.MEM_TIMEOUT(15), .CNT_W(32)) u_dut (
    .clk(clk), .arst(arst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_2_reg(mem_2_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .error(error), .retired(retired), .state(state)
  );

  // Narrow counter and disabled timeout: exercises wrap-around and the no-timeout build.
  multicycle_control_unit #(.MEM_TIMEOUT(0), .CNT_W(4)) u_wrap (
    .clk(clk), .arst(arst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write_w), .ir_write(ir_write_w), .i_or_d(i_or_d_w), .mem_read(mem_read_w),
    .mem_write(mem_write_w), .mem_2_reg(mem_2_reg_w), .reg_write(reg_write_w),
    .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w), .alu_op(alu_op_w), .pc_source(pc_source_w),
    .error(error_w), .retired(retired_w), .state(state_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic       z;
    logic [6:0] op;
    logic [3:0] st;
    bit         ret;
    bit         err;
  } step_t;

  step_t       plan[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_ret;
  bit          model_err;
  logic [6:0]  last_op;
  bit          tie_ready;

  // Strobe vector order: pc_write ir_write i_or_d mem_read mem_write mem_2_reg reg_write
  // alu_src_a alu_src_b alu_op pc_source, taken straight from the per-state output table.
  function automatic logic [13:0] exp_out(input logic [3:0] st, input logic rdy, input logic z);
    case (st)
      4'd0:    return {rdy, rdy, 1'b0, 1'b1, 3'b000, 1'b0, 2'b01, 2'b00, 2'b00};
      4'd1:    return {7'b0, 1'b0, 2'b10, 2'b00, 2'b00};
      4'd2:    return {7'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      4'd3:    return {7'b0, 1'b1, 2'b10, 2'b10, 2'b00};
      4'd4:    return {7'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      4'd5:    return {2'b00, 1'b1, 1'b1, 3'b000, 1'b0, 6'b0};
      4'd6:    return {5'b0, 1'b1, 1'b1, 1'b0, 6'b0};
      4'd7:    return {2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 6'b0};
      4'd8:    return {z, 6'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      4'd9:    return {1'b1, 6'b0, 1'b0, 2'b00, 2'b00, 2'b10};
      4'd10:   return {5'b0, 1'b0, 1'b1, 1'b0, 6'b0};
      default: return 14'b0;
    endcase
  endfunction

  function automatic string fmt(input logic [50:0] v);
    return $sformatf("state=%0d strobes=%b retired=%0d error=%b", v[50:47], v[46:33], v[32:1], v[0]);
  endfunction

  function automatic logic rnd_rdy();
    return tie_ready ? 1'b1 : 1'(($urandom() & 1));
  endfunction

  function automatic void push(input logic rdy, input logic z, input logic [6:0] op,
                               input logic [3:0] st, input bit ret, input bit err);
    step_t s;
    s.rdy = rdy; s.z = z; s.op = op; s.st = st; s.ret = ret; s.err = err;
    plan.push_back(s);
  endfunction

  // Expected per-cycle trace of one instruction, from the cycle counts of each class.
  function automatic void plan_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    bit legal;
    legal = (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
            (op == OP_BRANCH) || (op == OP_JAL);
    for (int i = 0; i < fw; i++) push(1'b0, z, last_op, 4'd0, 1'b0, 1'b0);
    push(1'b1, z, last_op, 4'd0, 1'b0, 1'b0);
    push(rnd_rdy(), z, op, 4'd1, 1'b0, !legal);
    if (op == OP_R || op == OP_I) begin
      push(rnd_rdy(), z, op, (op == OP_R) ? 4'd2 : 4'd3, 1'b0, 1'b0);
      push(rnd_rdy(), z, op, 4'd10, 1'b1, 1'b0);
    end else if (op == OP_LOAD) begin
      push(rnd_rdy(), z, op, 4'd4, 1'b0, 1'b0);
      for (int i = 0; i < mw; i++) push(1'b0, z, op, 4'd5, 1'b0, 1'b0);
      push(1'b1, z, op, 4'd5, 1'b0, 1'b0);
      push(rnd_rdy(), z, op, 4'd6, 1'b1, 1'b0);
    end else if (op == OP_STORE) begin
      push(rnd_rdy(), z, op, 4'd4, 1'b0, 1'b0);
      for (int i = 0; i < mw; i++) push(1'b0, z, op, 4'd7, 1'b0, 1'b0);
      push(1'b1, z, op, 4'd7, 1'b1, 1'b0);
    end else if (op == OP_BRANCH) begin
      push(rnd_rdy(), z, op, 4'd8, 1'b1, 1'b0);
    end else if (op == OP_JAL) begin
      push(rnd_rdy(), z, op, 4'd9, 1'b1, 1'b0);
    end
    last_op = op;
  endfunction

  // Drives one planned cycle from posedge+1, samples at the falling edge, then advances the model.
  task automatic exec_step(output logic [50:0] obs, output logic [50:0] exp,
                           output logic [7:0] obs_w, output logic [7:0] exp_w);
    step_t s;
    s = plan.pop_front();
    mem_ready = s.rdy;
    zero      = s.z;
    opcode    = s.op;
    #4;
    obs   = {state, pc_write, ir_write, i_or_d, mem_read, mem_write, mem_2_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_source, retired, error};
    exp   = {s.st, exp_out(s.st, s.rdy, s.z), model_ret, model_err};
    obs_w = {state_w, retired_w};
    exp_w = {s.st, model_ret[3:0]};
    @(posedge clk);
    #1;
    if (s.ret) model_ret = model_ret + 32'd1;
    if (s.err) model_err = 1'b1;
  endtask

  task automatic do_reset();
    arst      = 1'b1;
    model_ret = '0;
    model_err = 1'b0;
    last_op   = OP_R;
    plan.delete();
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic test_reset();
    logic [50:0] o, e;
    arst = 1'b1; opcode = OP_R; zero = 1'b0;
    for (int r = 1; r >= 0; r--) begin
      mem_ready = 1'(r);
      #1;
      o = {state, pc_write, ir_write, i_or_d, mem_read, mem_write, mem_2_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, retired, error};
      e = {4'd0, exp_out(4'd0, 1'(r), 1'b0), 32'd0, 1'b0};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL reset (mem_ready=%0d): got %s, expected %s", r, fmt(o), fmt(e));
      end
    end
    vectors++;
    if ({state_w, retired_w} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_wrap_inst: got state=%0d retired=%0d, expected 0/0", state_w, retired_w);
    end
    do_reset();
  endtask

  task automatic test_rtype();
    logic [50:0] o, e;
    logic [7:0]  ow, ew;
    int          n = 0;
    do_reset();
    tie_ready = 1'b1;
    plan_instr(OP_R, 0, 0, 1'b0);
    push(1'b1, 1'b0, OP_R, 4'd0, 1'b0, 1'b0);
    while (plan.size() > 0) begin
      exec_step(o, e, ow, ew);
      n++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL rtype cycle %0d: got %s, expected %s", n, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_load_wait();
    logic [50:0] o, e;
    logic [7:0]  ow, ew;
    int          n = 0;
    do_reset();
    tie_ready = 1'b1;
    plan_instr(OP_LOAD, 0, 3, 1'b1);
    push(1'b1, 1'b0, OP_LOAD, 4'd0, 1'b0, 1'b0);
    while (plan.size() > 0) begin
      exec_step(o, e, ow, ew);
      n++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL load_wait cycle %0d: got %s, expected %s", n, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_branch();
    logic [50:0] o, e;
    logic [7:0]  ow, ew;
    int          n = 0;
    do_reset();
    tie_ready = 1'b1;
    plan_instr(OP_BRANCH, 0, 0, 1'b1);
    plan_instr(OP_BRANCH, 0, 0, 1'b0);
    plan_instr(OP_JAL, 0, 0, 1'b0);
    push(1'b0, 1'b0, OP_JAL, 4'd0, 1'b0, 1'b0);
    while (plan.size() > 0) begin
      exec_step(o, e, ow, ew);
      n++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL branch cycle %0d: got %s, expected %s", n, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_illegal();
    logic [50:0] o, e;
    logic [7:0]  ow, ew;
    int          n = 0;
    do_reset();
    tie_ready = 1'b0;
    plan_instr(OP_BAD, 1, 0, 1'b0);
    for (int i = 0; i < 22; i++)
      push(rnd_rdy(), 1'($urandom() & 1), 7'($urandom()), 4'd11, 1'b0, 1'b0);
    while (plan.size() > 0) begin
      exec_step(o, e, ow, ew);
      n++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL illegal cycle %0d: got %s, expected %s", n, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_timeout();
    logic [50:0] o, e;
    logic [7:0]  ow, ew;
    int          n = 0;
    do_reset();
    tie_ready = 1'b0;
    for (int i = 0; i < 15; i++) push(1'b0, 1'b0, OP_R, 4'd0, 1'b0, 1'b0);
    push(1'b0, 1'b0, OP_R, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, OP_R, 4'd11, 1'b0, 1'b0);
    while (plan.size() > 0) begin
      exec_step(o, e, ow, ew);
      n++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL timeout cycle %0d: got %s, expected %s", n, fmt(o), fmt(e));
      end
    end
    vectors++;
    if ({state_w, error_w} !== 5'b0000_0) begin
      miscompares++;
      $display("[TB] FAIL timeout_disabled: got state=%0d error=%b, expected 0/0", state_w, error_w);
    end

    do_reset();
    n = 0;
    plan_instr(OP_R, 15, 0, 1'b0);
    while (plan.size() > 0) begin
      exec_step(o, e, ow, ew);
      n++; vectors++;
      if (o !== e || ow !== ew) begin
        miscompares++;
        $display("[TB] FAIL timeout_ready_wins cycle %0d: got %s, expected %s", n, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [50:0] o, e;
    logic [7:0]  ow, ew;
    int          n = 0;
    do_reset();
    tie_ready = 1'b1;
    for (int i = 0; i < 5; i++) plan_instr(OP_STORE, 0, 0, 1'b0);
    push(1'b1, 1'b0, OP_STORE, 4'd0, 1'b0, 1'b0);
    push(1'b1, 1'b0, OP_STORE, 4'd1, 1'b0, 1'b0);
    push(1'b1, 1'b0, OP_STORE, 4'd4, 1'b0, 1'b0);
    while (plan.size() > 0) begin
      exec_step(o, e, ow, ew);
      n++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL store_run cycle %0d: got %s, expected %s", n, fmt(o), fmt(e));
      end
    end
    mem_ready = 1'b0;
    #2;
    vectors++;
    if ({state, mem_write, retired} !== {4'd7, 1'b1, model_ret}) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_write: got state=%0d mem_write=%b retired=%0d, expected 7/1/%0d",
               state, mem_write, retired, model_ret);
    end
    arst = 1'b1;
    #1;
    vectors++;
    if ({state, mem_write, i_or_d, retired, error, retired_w} !== {4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL async_reset_abort: got state=%0d mem_write=%b i_or_d=%b retired=%0d error=%b, expected 0/0/0/0/0",
               state, mem_write, i_or_d, retired, error);
    end
    do_reset();
  endtask

  task automatic test_random_stream();
    logic [50:0] o, e;
    logic [7:0]  ow, ew;
    logic [6:0]  legal[6];
    int          n = 0;
    legal = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    do_reset();
    tie_ready = 1'b0;
    for (int i = 0; i < 40; i++)
      plan_instr(legal[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom() & 1));
    push(1'b0, 1'b0, last_op, 4'd0, 1'b0, 1'b0);
    while (plan.size() > 0) begin
      exec_step(o, e, ow, ew);
      n++; vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL random cycle %0d: got %s, expected %s", n, fmt(o), fmt(e));
      end
      vectors++;
      if (ow !== ew) begin
        miscompares++;
        $display("[TB] FAIL random_wrap cycle %0d: got state=%0d retired=%0d, expected state=%0d retired=%0d",
                 n, ow[7:4], ow[3:0], ew[7:4], ew[3:0]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tie_ready = 1'b1;
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_write();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequential control FSM for the multi-cycle RISC-V datapath. It steps each instruction through fetch, decode, execute, memory and write-back states and drives all datapath mux selects and write strobes. It handshakes with a variable-latency memory through `mem_ready`, aborts on a parametrised memory timeout or an unsupported opcode, and counts retired instructions.

## Interface
- `MEM_TIMEOUT`, 15: maximum consecutive wait cycles allowed in a memory state; 0 disables the timeout.
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk`  in  1  single clock, rising edge.
- `arst`  in  1  reset, asynchronous, active-high.
- `opcode`  in  7  instruction-register opcode, stable from DECODE until the next FETCH handshake.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `zero`  in  1  ALU zero flag.
- `pc_write`  out  1  PC load strobe.
- `ir_write`  out  1  IR load strobe.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `mem_2_reg`  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register-file write strobe.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = rs1.
- `alu_src_b`  out  2  ALU B select: 00 = rs2, 01 = const 4, 10 = imm.
- `alu_op`  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct-decoded.
- `pc_source`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `error`  out  1  sticky fault flag.
- `retired`  out  `CNT_W`  retired-instruction count.
- `state`  out  4  current state encoding, for debug.

## Operation
- State encodings: FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, MEM_ADDR = 4, MEM_RD = 5, MEM_WB = 6, MEM_WR = 7, BRANCH = 8, JUMP = 9, ALU_WB = 10, HALT = 11. Encodings 12–15 behave as HALT.
- Outputs are a combinational decode of `state`, plus `mem_ready` or `zero` where stated below. Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write` = `pc_write` = `mem_ready`. On `mem_ready` the next state is DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=10, `alu_op`=00; the branch target is computed here. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JUMP
  - any other opcode → HALT, and `error` is set.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10 → ALU_WB.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=10 → ALU_WB.
- ALU_WB: `reg_write`=1, `mem_2_reg`=0 → FETCH; retires the instruction.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 → MEM_RD if opcode is 0000011, otherwise MEM_WR.
- MEM_RD: `mem_read`=1, `i_or_d`=1. On `mem_ready` → MEM_WB.
- MEM_WB: `reg_write`=1, `mem_2_reg`=1 → FETCH; retires.
- MEM_WR: `mem_write`=1, `i_or_d`=1. On `mem_ready` → FETCH; retires in the handshake cycle.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01, `pc_write` = `zero` → FETCH; retires.
- JUMP: `pc_source`=10, `pc_write`=1 → FETCH; retires. No link write in this generation.
- HALT: all strobes 0. The block stays in HALT with `error`=1 until `arst`.
- Wait counter, width clog2(`MEM_TIMEOUT`+1):
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with `mem_ready`=0.
  - Clears on every state change.
  - If the counter equals `MEM_TIMEOUT` and `mem_ready`=0, the next state is HALT and `error` is set.
  - `mem_ready` in that same cycle wins: the handshake completes normally.
- `retired` increments by 1 on each retiring transition and wraps from 2^`CNT_W`−1 to 0.

## Timing
- Reset: `arst`=1 forces `state`=FETCH, `retired`=0, `error`=0 and wait counter = 0 immediately, with no clock edge needed. Outputs then take their FETCH values: `mem_read`=1, `alu_src_b`=01, `ir_write` = `pc_write` = `mem_ready`, all others 0.
- Reset mid-operation aborts the current instruction without retiring it. Any strobe that was high drops in the same cycle.
- State updates on the rising edge of `clk` after `arst` deasserts.
- Cycles per instruction with `mem_ready` tied 1: R/I-type 4, load 5, store 4, branch 3, jump 3.
- Each `mem_ready`=0 cycle in a wait state adds 1 cycle.
- With `MEM_TIMEOUT`=N>0, a wait state with no ready lasts N+1 cycles, then HALT.
- `zero` is sampled only in BRANCH.
- `opcode` is sampled only in DECODE and MEM_ADDR.

## Test plan
- R-type: reset, `mem_ready`=1, `opcode`=0110011 → `state` sequence 0,1,2,10,0; `reg_write`=1 only in cycle 4; `retired`=1.
- Load with memory wait: `opcode`=0000011, `mem_ready`=0 for 3 cycles in MEM_RD → MEM_RD lasts 4 cycles with `mem_read`=1 and `i_or_d`=1, then MEM_WB with `mem_2_reg`=1; 8 cycles total; `retired`=1.
- Branch taken/not taken: BRANCH with `zero`=1 → `pc_write`=1 and `pc_source`=01; with `zero`=0 → `pc_write`=0. `retired` increments in both cases.
- Illegal opcode: `opcode`=0000000 → DECODE goes to HALT; `error`=1; all strobes stay 0 for 20+ cycles until `arst`.
- Timeout: default `MEM_TIMEOUT`=15, `mem_ready`=0 in FETCH → 16 FETCH cycles, then HALT with `error`=1. Repeat with `mem_ready`=1 on the 16th cycle → DECODE and no error.
- Reset mid-MEM_WR with `retired`=5 → `mem_write` falls asynchronously; `state`=0, `retired`=0. Separately, force `retired` to 2^32−1 (or run with `CNT_W`=4 for 16 instructions) and retire one more → `retired` wraps to 0.
